// File: rtl/fixed_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fixed_div_pkg
// Description : Shared definitions for the fixed-point divider: default
//               operand geometry, FSM state type, saturation constants and
//               a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fixed_div_pkg;

    // Default operand width and fractional bits (Q7.8).
    localparam int DATA_W = 16;
    localparam int FRAC   = 8;

    // Saturation codes at the default width.
    localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bits needed to count 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_div_sub_step.sv
`default_nettype none
// ============================================================================
// Module      : fixed_sub_step
// Description : One restoring-division step. Shifts the next numerator bit
//               into the partial remainder, trial-subtracts the divisor and
//               either keeps the difference (quotient bit 1) or restores the
//               shifted remainder (quotient bit 0). Purely combinational.
// Ports       : rem_in   - current partial remainder (always < divisor)
//               bit_in   - next numerator bit, MSB first
//               divisor  - divisor magnitude
//               rem_out  - next partial remainder
//               q_bit    - quotient bit produced by this step
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_sub_step #(
    parameter int REM_W = 17
) (
    input  logic [REM_W-1:0] rem_in,
    input  logic             bit_in,
    input  logic [REM_W-1:0] divisor,
    output logic [REM_W-1:0] rem_out,
    output logic             q_bit
);

    // One extra bit so the trial difference carries a valid sign.
    logic [REM_W:0] w_trial;
    logic [REM_W:0] w_diff;

    assign w_trial = {rem_in, bit_in};
    assign w_diff  = w_trial - {1'b0, divisor};
    assign q_bit   = ~w_diff[REM_W];
    assign rem_out = q_bit ? w_diff[REM_W-1:0] : w_trial[REM_W-1:0];

endmodule
`default_nettype wire

// File: rtl/fixed_div.sv
`default_nettype none
// ============================================================================
// Module      : fixed_div
// Description : Signed fixed-point divider. Computes
//               (dividend * 2^FRAC) / divisor truncated toward zero using a
//               restoring divider, one quotient bit per cycle, with
//               saturation and divide-by-zero reporting. Fixed latency of
//               DATA_W+FRAC+1 edges from acceptance to out_valid.
// Ports       : clk, rst_n           - clock, async active-low reset
//               in_valid / in_ready  - operand handshake (ready only in IDLE)
//               dividend, divisor    - signed fixed-point operands
//               out_valid / out_ready- result handshake
//               quotient             - signed fixed-point result
//               sat                  - result was clamped
//               div_zero             - divisor was zero
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_div #(
    parameter int DATA_W = fixed_div_pkg::DATA_W,
    parameter int FRAC   = fixed_div_pkg::FRAC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] quotient,
    output logic              sat,
    output logic              div_zero
);

    import fixed_div_pkg::*;

    localparam int c_iters = DATA_W + FRAC;
    localparam int c_cnt_w = cnt_width(c_iters);
    localparam int c_num_w = DATA_W + FRAC;
    localparam int c_rem_w = DATA_W + 1;

    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(c_iters - 1);
    localparam logic [DATA_W-1:0]  c_sat_pos = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]  c_sat_neg = {1'b1, {(DATA_W-1){1'b0}}};
    // Largest representable magnitudes, widened to the raw quotient width.
    localparam logic [c_num_w-1:0] c_pos_max = {{(FRAC+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic [c_num_w-1:0] c_neg_max = c_pos_max + c_num_w'(1);

    state_t r_state;
    state_t w_next;

    logic               w_load;
    logic               w_iter;
    logic               w_fix;

    logic [c_num_w-1:0] r_num;      // numerator magnitude, shifted out MSB first
    logic [c_num_w-1:0] r_quo;      // raw quotient magnitude
    logic [c_rem_w-1:0] r_rem;      // partial remainder
    logic [DATA_W-1:0]  r_dsr;      // divisor magnitude
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_neg;      // result sign
    logic               r_dvd_neg;  // dividend sign, for divide-by-zero clamp
    logic               r_dz;

    logic [DATA_W-1:0]  r_quotient;
    logic               r_sat;
    logic               r_div_zero;

    logic [DATA_W-1:0]  w_dvd_mag;
    logic [DATA_W-1:0]  w_dsr_mag;
    logic [c_rem_w-1:0] w_rem_next;
    logic               w_q_bit;
    logic [DATA_W-1:0]  w_fix_q;
    logic               w_fix_sat;

    // Magnitudes stay DATA_W bits wide: the most negative value maps to
    // 2^(DATA_W-1) as an unsigned number.
    assign w_dvd_mag = dividend[DATA_W-1] ? (~dividend + DATA_W'(1)) : dividend;
    assign w_dsr_mag = divisor[DATA_W-1]  ? (~divisor  + DATA_W'(1)) : divisor;

    fixed_sub_step #(
        .REM_W (c_rem_w)
    ) u_step (
        .rem_in  (r_rem),
        .bit_in  (r_num[c_num_w-1]),
        .divisor ({1'b0, r_dsr}),
        .rem_out (w_rem_next),
        .q_bit   (w_q_bit)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_iter = 1'b0;
        w_fix  = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_load = 1'b1;
                    w_next = ITER;
                end
            end
            ITER: begin
                w_iter = 1'b1;
                if (r_cnt == c_last) begin
                    w_next = FIX;
                end
            end
            FIX: begin
                w_fix  = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sign application and saturation of the raw magnitude
    // ------------------------------------------------------------------
    always_comb begin
        w_fix_q   = '0;
        w_fix_sat = 1'b0;
        if (r_dz) begin
            w_fix_sat = 1'b1;
            w_fix_q   = r_dvd_neg ? c_sat_neg : c_sat_pos;
        end else if (r_neg) begin
            if (r_quo > c_neg_max) begin
                w_fix_sat = 1'b1;
                w_fix_q   = c_sat_neg;
            end else begin
                // Magnitude fits in DATA_W bits here; a zero magnitude
                // negates to zero.
                w_fix_q = ~r_quo[DATA_W-1:0] + DATA_W'(1);
            end
        end else begin
            if (r_quo > c_pos_max) begin
                w_fix_sat = 1'b1;
                w_fix_q   = c_sat_pos;
            end else begin
                w_fix_q = r_quo[DATA_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num      <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dsr      <= '0;
            r_cnt      <= '0;
            r_neg      <= 1'b0;
            r_dvd_neg  <= 1'b0;
            r_dz       <= 1'b0;
            r_quotient <= '0;
            r_sat      <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            if (w_load) begin
                r_num     <= c_num_w'(w_dvd_mag) << FRAC;
                r_quo     <= '0;
                r_rem     <= '0;
                r_cnt     <= '0;
                r_dsr     <= w_dsr_mag;
                r_neg     <= dividend[DATA_W-1] ^ divisor[DATA_W-1];
                r_dvd_neg <= dividend[DATA_W-1];
                r_dz      <= (divisor == '0);
            end
            if (w_iter) begin
                r_num <= r_num << 1;
                r_rem <= w_rem_next;
                r_quo <= {r_quo[c_num_w-2:0], w_q_bit};
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
            if (w_fix) begin
                r_quotient <= w_fix_q;
                r_sat      <= w_fix_sat;
                r_div_zero <= r_dz;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign quotient  = r_quotient;
    assign sat       = r_sat;
    assign div_zero  = r_div_zero;

endmodule
`default_nettype wire

// File: doc/fixed_div.md
FIXED_DIV -- requirements
Module: fixed_div

Interface
REQ-001 Parameter DATA_W, default 16: operand/result width, signed two's complement.
REQ-002 Parameter FRAC, default 8: fractional bits of operands and result (Q7.8 at defaults).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  dividend/divisor valid.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 dividend  input  DATA_W  signed fixed-point numerator.
REQ-008 divisor  input  DATA_W  signed fixed-point denominator.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 quotient  output  DATA_W  signed fixed-point result.
REQ-012 sat  output  1  result was clamped.
REQ-013 div_zero  output  1  divisor was zero.

Function
REQ-014 The block SHALL compute quotient = (dividend * 2^FRAC) / divisor, truncated toward zero, by restoring division, one quotient bit per cycle.
REQ-015 The FSM SHALL have states IDLE, ITER, FIX, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; an operation is accepted on an edge where in_valid && in_ready.
REQ-017 On acceptance, the block SHALL register |dividend| (DATA_W bits, so -32768 gives 32768), |divisor|, the result sign (sign XOR), a divisor==0 flag, and SHALL enter ITER.
REQ-018 ITER SHALL run exactly DATA_W+FRAC cycles (24 at defaults): shift in the next dividend-magnitude bit (zeros after the MSB-first dividend bits), trial-subtract |divisor|, keep the difference and set the quotient bit to 1 when non-negative, else restore and set 0.
REQ-019 FIX SHALL take one cycle: apply sign, saturate, register quotient/sat/div_zero, then enter DONE.
REQ-020 out_valid SHALL rise after the (DATA_W+FRAC+1)th rising edge following acceptance (25 at defaults); latency is fixed and data-independent, including divide-by-zero.
REQ-021 Saturation: positive result with magnitude > 2^(DATA_W-1)-1 -> 0x7FFF, sat=1; negative result with magnitude > 2^(DATA_W-1) -> 0x8000, sat=1; otherwise sat=0.
REQ-022 Divide-by-zero: div_zero=1, sat=1, quotient=0x7FFF when dividend>=0 (including 0), 0x8000 when dividend<0.
REQ-023 A zero magnitude result SHALL be 0x0000 regardless of sign.
REQ-024 In DONE, quotient/sat/div_zero/out_valid SHALL hold stable while out_ready=0.
REQ-025 On an edge with out_valid && out_ready, the FSM SHALL return to IDLE, with out_valid=0 and in_ready=1 after that edge; back-to-back throughput is one operation per DATA_W+FRAC+3 cycles.
REQ-026 in_valid and operand changes outside IDLE SHALL be ignored.

Reset
REQ-027 rst_n low SHALL immediately force IDLE: in_ready=1, out_valid=0, quotient=0, sat=0, div_zero=0, and clear internal remainder, counter and quotient registers.
REQ-028 Reset asserted mid-ITER or in DONE SHALL abort the operation, with no result delivered.
REQ-029 The first acceptance is possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 A shared package SHALL hold DATA_W, FRAC, the FSM state typedef, and the constants SAT_POS=0x7FFF and SAT_NEG=0x8000.
REQ-031 The iteration step SHALL be one sub-module, fixed_sub_step: combinational trial subtract that returns the next remainder and quotient bit.
REQ-032 The iteration counter SHALL be ceil(log2(DATA_W+FRAC+1)) bits wide.

Verification
REQ-033 dividend=0x0300 (3.0), divisor=0x0200 (2.0) -> quotient=0x0180, sat=0, div_zero=0, out_valid exactly 25 edges after acceptance.
REQ-034 dividend=0xFD00 (-3.0), divisor=0x0200 -> 0xFE80; dividend=0x0100, divisor=0xFD00 -> 0xFFAB (-0.33, truncated toward zero).
REQ-035 dividend=0x7FFF, divisor=0x0001 -> 0x7FFF, sat=1; dividend=0x8000, divisor=0x0100 -> 0x8000, sat=0.
REQ-036 dividend=0x0100, divisor=0 -> 0x7FFF, sat=1, div_zero=1; dividend=0xFF00, divisor=0 -> 0x8000, div_zero=1; both with 25-edge latency.
REQ-037 Hold out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0; then out_ready=1 -> in_ready=1 on the next cycle. Second operation is accepted and completes correctly.
REQ-038 Pulse rst_n low at ITER cycle 10 -> outputs at reset values, no out_valid. A new operation 0x0300/0x0200 after reset -> 0x0180.
